// File: rtl/mem_loader_pkg.sv
// Shared types and protocol constants for the byte-stream RAM loader.
package mem_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_AH,
        S_AL,
        S_LH,
        S_LL,
        S_WDATA,
        S_RREQ,
        S_RWAIT,
        S_RSEND,
        S_ACK,
        S_ERR
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h2E;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

endpackage

// File: rtl/mem_loader.sv
// Byte-stream bus master: parses W/R command frames from rx, writes or reads
// the 64 KiB RAM and answers on tx, holding the CPU off RAM while busy.
module mem_loader
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_hold
);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        rx_ready_q, rx_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic        rx_fire;
    logic        tx_fire;
    logic [15:0] len_full;

    assign rx_fire  = rx_valid & rx_ready_q;
    assign tx_fire  = tx_valid_q & tx_ready;
    assign len_full = {len_q[15:8], rx_data};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cmd_d       = cmd_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: if (rx_fire) begin
                cmd_d = rx_data;
                if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                    state_d = S_AH;
                end else begin
                    state_d    = S_ERR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ERR;
                end
            end
            S_AH: if (rx_fire) begin
                addr_d[15:8] = rx_data;
                state_d      = S_AL;
            end
            S_AL: if (rx_fire) begin
                addr_d[7:0] = rx_data;
                state_d     = S_LH;
            end
            S_LH: if (rx_fire) begin
                len_d[15:8] = rx_data;
                state_d     = S_LL;
            end
            S_LL: if (rx_fire) begin
                len_d = len_full;
                if (len_full == 16'h0000) begin
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ACK;
                end else if (cmd_q == CMD_WRITE) begin
                    state_d = S_WDATA;
                end else begin
                    state_d    = S_RREQ;
                    mem_addr_d = addr_q;
                end
            end
            // Write strobe is registered, so it lands one cycle after the accept.
            S_WDATA: if (rx_fire) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = rx_data;
                addr_d      = addr_q + 16'd1;
                len_d       = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ACK;
                end
            end
            S_RREQ:  state_d = S_RWAIT;
            S_RWAIT: begin
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                state_d    = S_RSEND;
            end
            S_RSEND: if (tx_fire) begin
                addr_d = addr_q + 16'd1;
                len_d  = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    state_d   = S_ACK;
                    tx_data_d = RSP_ACK;
                end else begin
                    state_d    = S_RREQ;
                    tx_valid_d = 1'b0;
                    mem_addr_d = addr_q + 16'd1;
                end
            end
            S_ACK, S_ERR: if (tx_fire) begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_AH) || (state_d == S_AL) ||
                     (state_d == S_LH) || (state_d == S_LL) || (state_d == S_WDATA);
        cpu_hold_d = (state_d != S_IDLE) || mem_we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    // Frame fields are only meaningful once loaded from the stream.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
        cmd_q  <= cmd_d;
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a synchronous RAM model and tx/write monitors.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cpu_hold;

    logic [7:0]  ram [0:65535];
    logic [7:0]  tx_q [$];
    int          tx_cyc [$];
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic        wr_ack_q [$];
    int          cyc = 0;
    bit          stall_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_ack_q.push_back(tx_valid && tx_data == 8'h2E);
        end
    end

    always @(negedge clk) tx_ready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_ack_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b [$]);
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tx_count", 32'(tx_q.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] fr [$];

        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // Three-byte write
        clear_logs();
        fr = '{8'h57, 8'h12, 8'h34, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr);
        wait_tx(1);
        check("wr_ack", 32'(tx_q[0]), 32'h2E);
        check("wr_cpu_hold_released", 32'(cpu_hold), 32'd0);
        check("wr_count", 32'(wr_addr_q.size()), 32'd3);
        if (wr_addr_q.size() == 3) begin
            check("wr0_addr", 32'(wr_addr_q[0]), 32'h1234);
            check("wr0_data", 32'(wr_data_q[0]), 32'hAA);
            check("wr1_addr", 32'(wr_addr_q[1]), 32'h1235);
            check("wr1_data", 32'(wr_data_q[1]), 32'hBB);
            check("wr2_addr", 32'(wr_addr_q[2]), 32'h1236);
            check("wr2_data", 32'(wr_data_q[2]), 32'hCC);
            check("wr0_not_ack", 32'(wr_ack_q[0]), 32'd0);
            check("wr_last_with_ack", 32'(wr_ack_q[2]), 32'd1);
        end

        // Read back with random tx stalls
        clear_logs();
        stall_en = 1'b1;
        fr = '{8'h52, 8'h12, 8'h34, 8'h00, 8'h03};
        send_frame(fr);
        wait_tx(4);
        stall_en = 1'b0;
        if (tx_q.size() == 4) begin
            check("rd0", 32'(tx_q[0]), 32'hAA);
            check("rd1", 32'(tx_q[1]), 32'hBB);
            check("rd2", 32'(tx_q[2]), 32'hCC);
            check("rd_ack", 32'(tx_q[3]), 32'h2E);
            check("rd_gap01", 32'(tx_cyc[1] - tx_cyc[0] >= 3), 32'd1);
            check("rd_gap12", 32'(tx_cyc[2] - tx_cyc[1] >= 3), 32'd1);
        end
        check("rd_no_writes", 32'(wr_addr_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("rd_cpu_hold_released", 32'(cpu_hold), 32'd0);

        // Address wrap-around
        clear_logs();
        fr = '{8'h57, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
        send_frame(fr);
        wait_tx(1);
        check("wrap_ack", 32'(tx_q[0]), 32'h2E);
        check("wrap_count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("wrap0_addr", 32'(wr_addr_q[0]), 32'hFFFF);
            check("wrap0_data", 32'(wr_data_q[0]), 32'h11);
            check("wrap1_addr", 32'(wr_addr_q[1]), 32'h0000);
            check("wrap1_data", 32'(wr_data_q[1]), 32'h22);
        end

        // Zero-length write
        clear_logs();
        fr = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00};
        send_frame(fr);
        check("len0_tx_valid_now", 32'(tx_valid), 32'd1);
        wait_tx(1);
        check("len0_ack", 32'(tx_q[0]), 32'h2E);
        check("len0_no_writes", 32'(wr_addr_q.size()), 32'd0);

        // Bad command, then a normal frame parsed from the next byte
        clear_logs();
        send_byte(8'h41);
        check("err_rx_ready_low", 32'(rx_ready), 32'd0);
        wait_tx(1);
        check("err_rsp", 32'(tx_q[0]), 32'h3F);
        fr = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h01, 8'h5A};
        send_frame(fr);
        wait_tx(2);
        check("after_err_ack", 32'(tx_q[1]), 32'h2E);
        check("after_err_wcount", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("after_err_addr", 32'(wr_addr_q[0]), 32'h0020);
            check("after_err_data", 32'(wr_data_q[0]), 32'h5A);
        end

        // Reset after second data byte of a 4-byte write
        clear_logs();
        fr = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
        send_frame(fr);
        check("abort_pending_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wcount", 32'(wr_addr_q.size()), 32'd2);
        check("abort_rx_ready", 32'(rx_ready), 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_tx_data", 32'(tx_data), 32'h00);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'h0000);
        check("abort_mem_wdata", 32'(mem_wdata), 32'h00);
        check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_ack", 32'(tx_q.size()), 32'd0);
        check("abort_no_more_writes", 32'(wr_addr_q.size()), 32'd2);
        check("abort_rx_ready_back", 32'(rx_ready), 32'd1);
        check("abort_ram_kept", 32'(ram[16'h3001]), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream bus master for the 64 KiB system RAM: it decodes a small command protocol from a byte-wide receive stream and writes bytes into RAM or reads them back out to a transmit stream. It sits between the host serial link and the RAM port, taking the RAM away from the 65C02 while a command is in progress. The external address/write-enable mux uses `cpu_hold` to select between the CPU and the loader.

## Interface
- No parameters; address width is fixed at 16 and data width at 8.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts the byte this cycle.
- `tx_data` out 8: outgoing byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts `tx_data` this cycle.
- `mem_addr` out 16: RAM address.
- `mem_we` out 1: RAM write strobe, active for one cycle per byte.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data; valid one cycle after the address is presented with `mem_we`=0; not updated in write cycles.
- `cpu_hold` out 1: high whenever the loader owns RAM.

## Operation
- Handshakes:
  - rx transfer occurs when `rx_valid`&`rx_ready`.
  - tx transfer occurs when `tx_valid`&`tx_ready`.
  - `tx_valid`/`tx_data` stay stable until the transfer completes.
- Command frame: CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO.
  - LEN is a 16-bit byte count.
  - LEN=0 means no data phase.
- CMD 0x57 (write): exactly LEN data bytes follow; each accepted byte is written to the current address, then the address increments.
- CMD 0x52 (read): LEN bytes are read from consecutive addresses and sent on tx.
- After every completed W or R command the loader sends 0x2E, then returns to IDLE.
- Any other CMD byte: send 0x3F, return to IDLE; ADDR/LEN bytes are not consumed.
- Address arithmetic is 16-bit modulo; 0xFFFF increments to 0x0000.
- Length counter is 16-bit and decrements to 0.
- States and transitions:
  - IDLE: `rx_ready`=1. Accepted byte 0x57/0x52 -> AH; any other byte -> ERR.
  - AH -> AL -> LH -> LL: one accepted byte per state, `rx_ready`=1 throughout.
  - LL exit: LEN=0 -> ACK; W -> WDATA; R -> RREQ.
  - WDATA: `rx_ready`=1. Each accepted byte registers `mem_we`=1, `mem_addr`, `mem_wdata` for the next cycle only. Last byte -> ACK.
  - RREQ: drive `mem_addr`, `mem_we`=0 -> RWAIT.
  - RWAIT: capture `mem_rdata` into `tx_data`, set `tx_valid` -> RSEND.
  - RSEND: on tx transfer, increment the address and decrement the count; count now 0 -> ACK, else -> RREQ.
  - ACK: drive 0x2E. ERR: drive 0x3F. Both -> IDLE on tx transfer.
- `rx_ready`=0 in every state other than IDLE, AH, AL, LH, LL, WDATA.
- `cpu_hold`=1 in every state except IDLE, and also for the cycle in which a write strobe is still pending while the FSM has already reached ACK.

## Timing
- All outputs are registered.
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0x00, `mem_we`=0, `mem_addr`=0x0000, `mem_wdata`=0x00, `cpu_hold`=0. State is IDLE.
- `rx_ready` rises in the first cycle after `rst` deasserts.
- Write latency: the byte accepted at edge N is written at edge N+1. Throughput is one byte per cycle.
- Read cycle per byte: RREQ, RWAIT, then RSEND for at least 1 cycle. Minimum is 3 cycles per byte, and `tx_valid` asserts 2 cycles after RREQ entry.
- Write-then-ACK: the `mem_we` pulse for the last byte coincides with the first ACK cycle.
- Reset mid-command: abort immediately; no further `mem_we`. Bytes already written remain in RAM. No ACK is sent.
- `rx_valid` while `rx_ready`=0 is ignored and the byte is not lost (stream semantics).
- `tx_ready` held low stalls indefinitely. State and memory outputs hold, `mem_we`=0.

## Structure
- Shared package `mem_loader_pkg`:
  - FSM state enum.
  - Constants `CMD_WRITE`=8'h57, `CMD_READ`=8'h52, `RSP_ACK`=8'h2E, `RSP_ERR`=8'h3F.
- Single module with no sub-modules. The address and length counters and the FSM live inline.

## Test plan
- Write 3 bytes: send 57 12 34 00 03 AA BB CC.
  - Expect `mem_we` pulses at 0x1234/AA, 0x1235/BB, 0x1236/CC.
  - Then tx 0x2E, then `cpu_hold`=0.
- Read back the same range with 52 12 34 00 03 and the RAM model attached.
  - Expect tx AA, BB, CC, 2E.
  - Expect ≥3 cycles between reads, with random `tx_ready` stalls.
- Wrap-around: write 57 FF FF 00 02 11 22.
  - Expect writes at 0xFFFF and 0x0000.
- Edge commands:
  - LEN=0 write (57 00 10 00 00): expect immediate 0x2E and no `mem_we`.
  - Bad CMD 0x41: expect 0x3F, after which the next byte is parsed as CMD.
- Reset after the 2nd data byte of a 4-byte write.
  - Expect exactly 2 writes and no ACK.
  - Expect all outputs at reset values and `cpu_hold`=0 the next cycle.
